// File: rtl/voice_mixer_if.sv
// Bus bundle between a voice_mixer and whatever drives its voices and consumes its samples.
// Every strobe on this bus is a one-cycle pulse with no back-pressure; there is no ready/valid pairing.
interface voice_mixer_if #(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16
);
  logic                               generate_next_sample;
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples;
  logic [NUM_VOICES-1:0]              voice_ready;
  logic [NUM_VOICES-1:0]              voice_mask;
  logic [1:0]                         gain_shift;
  logic                               mute;
  logic [SAMPLE_WIDTH-1:0]            sample_out;
  logic                               sample_valid;
  logic [NUM_VOICES-1:0]              missed_voices;
  logic                               overrun;
  logic                               busy;

  modport master (
    output generate_next_sample, voice_samples, voice_ready, voice_mask, gain_shift, mute,
    input  sample_out, sample_valid, missed_voices, overrun, busy
  );

  modport slave (
    input  generate_next_sample, voice_samples, voice_ready, voice_mask, gain_shift, mute,
    output sample_out, sample_valid, missed_voices, overrun, busy
  );
endinterface

// File: rtl/voice_mixer.sv
// Collects one sample per masked voice, sums them serially, applies gain and saturation,
// and emits one mixed sample per generate_next_sample request.
module voice_mixer #(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               reset,
  voice_mixer_if.slave       bus,
  output logic [1:0]         state_dbg
);
  localparam int AW = SAMPLE_WIDTH + $clog2(NUM_VOICES);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ACCUM   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_VOICES-1:0]   mask_q, mask_d;
  logic [NUM_VOICES-1:0]   cap_q, cap_d;
  logic [NUM_VOICES-1:0]   missed_q, missed_d;
  logic [SAMPLE_WIDTH-1:0] samp_q [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0] samp_d [NUM_VOICES];
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, busy_d;

  logic signed [AW-1:0]    addend;
  logic signed [AW-1:0]    shifted;
  logic [SAMPLE_WIDTH-1:0] saturated;

  // Voices that timed out were never captured, so gating by the capture flag makes them add zero.
  always_comb begin
    addend = '0;
    if (cap_q[idx_q]) addend = AW'($signed(samp_q[idx_q]));
  end

  always_comb begin
    shifted = acc_q >>> bus.gain_shift;
    if (shifted > SAT_MAX)      saturated = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (shifted < SAT_MIN) saturated = SAT_MIN[SAMPLE_WIDTH-1:0];
    else                        saturated = shifted[SAMPLE_WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cap_d     = cap_q;
    missed_d  = missed_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    overrun_d = bus.generate_next_sample && (state_q != S_IDLE);
    for (int i = 0; i < NUM_VOICES; i++) samp_d[i] = samp_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.generate_next_sample) begin
          state_d = S_COLLECT;
          mask_d  = bus.voice_mask;
          cap_d   = '0;
          timer_d = '0;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_COLLECT: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (mask_q[i] && !cap_q[i] && bus.voice_ready[i]) begin
            cap_d[i]  = 1'b1;
            samp_d[i] = bus.voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          end
        end
        timer_d = timer_q + TW'(1);
        // cap_d already includes this cycle's captures, so a final ready pulse exits immediately.
        if (((cap_d & mask_q) == mask_q) || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d  = S_ACCUM;
          missed_d = mask_q & ~cap_d;
          idx_d    = '0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_VOICES - 1)) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        out_d   = bus.mute ? '0 : saturated;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      cap_q     <= '0;
      missed_q  <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) samp_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      missed_q  <= missed_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_VOICES; i++) samp_q[i] <= samp_d[i];
    end
  end

  assign bus.sample_out    = out_q;
  assign bus.sample_valid  = valid_q;
  assign bus.missed_voices = missed_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = busy_q;
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed mixes, timeout, overrun and reset abort,
// with expected samples queued at stimulus time and compared when sample_valid strobes.
module tb_voice_mixer;
  localparam int NV = 3;
  localparam int SW = 16;
  localparam int W  = NV + SW;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         valid_cnt = 0;
  int         valid_cyc = 0;
  int         ovr_cnt = 0;
  int         ovr_cyc = 0;
  logic [W-1:0] exp_q[$];

  voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW)) bus ();

  voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.sample_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sample_out", 32'(bus.sample_out), 32'(e[SW-1:0]));
        check("missed_voices", 32'(bus.missed_voices), 32'(e[W-1:SW]));
      end
    end
    if (bus.overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  function automatic logic [SW-1:0] exp_mix(input logic [NV-1:0] used, input logic signed [SW-1:0] s0,
                                            input logic signed [SW-1:0] s1, input logic signed [SW-1:0] s2,
                                            input logic [1:0] g, input logic m);
    int sum;
    sum = 0;
    if (used[0]) sum += int'(s0);
    if (used[1]) sum += int'(s1);
    if (used[2]) sum += int'(s2);
    sum = sum >>> g;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    if (m) sum = 0;
    return sum[SW-1:0];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gain and mute are driven inverted here and corrected later, so only their OUTPUT-cycle value may matter.
  task automatic drive_period(input logic [NV-1:0] mask, input logic [NV-1:0] rdy,
                              input logic signed [SW-1:0] s0, input logic signed [SW-1:0] s1,
                              input logic signed [SW-1:0] s2, input logic [1:0] gain,
                              input logic mute_in, output int gen_c);
    bus.voice_samples        = {s2, s1, s0};
    bus.voice_mask           = mask;
    bus.gain_shift           = ~gain;
    bus.mute                 = ~mute_in;
    bus.generate_next_sample = 1'b1;
    gen_c = cyc + 1;
    tick();
    bus.generate_next_sample = 1'b0;
    for (int i = 0; i < NV; i++) begin
      bus.voice_ready = rdy[i] ? NV'(1 << i) : '0;
      tick();
    end
    bus.voice_ready = '0;
  endtask

  task automatic run_mix(input logic [NV-1:0] mask, input logic [NV-1:0] rdy,
                         input logic signed [SW-1:0] s0, input logic signed [SW-1:0] s1,
                         input logic signed [SW-1:0] s2, input logic [1:0] gain,
                         input logic mute_in, input int dist_off);
    int gen_c, lat, hi, vc0, oc0, k;
    logic [SW-1:0] e;
    logic [NV-1:0] miss;
    miss = mask & ~rdy;
    e = exp_mix(mask & rdy, s0, s1, s2, gain, mute_in);
    exp_q.push_back({miss, e});
    if (miss != '0) lat = 64 + 4;
    else begin
      hi = 0;
      for (int i = 0; i < NV; i++) if (mask[i]) hi = i;
      lat = 1 + hi + 4;
    end
    vc0 = valid_cnt;
    oc0 = ovr_cnt;
    drive_period(mask, rdy, s0, s1, s2, gain, mute_in, gen_c);
    bus.gain_shift = gain;
    bus.mute       = mute_in;
    k = 0;
    while (valid_cnt == vc0 && k < 200) begin
      bus.generate_next_sample = (dist_off > 0) && (cyc + 1 == gen_c + dist_off);
      tick();
      k++;
    end
    bus.generate_next_sample = 1'b0;
    check("valid_seen", 32'(valid_cnt != vc0), 32'd1);
    check("latency", 32'(valid_cyc - gen_c), 32'(lat));
    tick();
    tick();
    check("valid_once", 32'(valid_cnt - vc0), 32'd1);
    check("hold", 32'(bus.sample_out), 32'(e));
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("overrun_cnt", 32'(ovr_cnt - oc0), 32'(dist_off > 0));
    if (dist_off > 0) check("overrun_cyc", 32'(ovr_cyc - gen_c), 32'(dist_off));
  endtask

  initial begin
    int gen_c, vc0;
    logic [NV-1:0]        rm;
    logic signed [SW-1:0] r0, r1, r2;
    logic [1:0]           rg;

    rst_n                    = 1'b0;
    bus.generate_next_sample = 1'b0;
    bus.voice_samples        = '0;
    bus.voice_ready          = '0;
    bus.voice_mask           = '0;
    bus.gain_shift           = '0;
    bus.mute                 = 1'b0;
    repeat (3) tick();
    check("rst_sample_out", 32'(bus.sample_out), 32'd0);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_missed", 32'(bus.missed_voices), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    bus.voice_ready = 3'b111;
    tick();
    bus.voice_ready = '0;
    check("idle_after_rst", 32'(bus.busy), 32'd0);
    tick();

    run_mix(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd0, 1'b0, 0);
    run_mix(3'b111, 3'b111, 16'sd30000, 16'sd30000, 16'sd30000, 2'd0, 1'b0, 0);
    run_mix(3'b111, 3'b111, -16'sd30000, -16'sd30000, -16'sd30000, 2'd0, 1'b0, 0);
    run_mix(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd2, 1'b0, 0);
    run_mix(3'b111, 3'b111, -16'sd3, -16'sd2, -16'sd2, 2'd1, 1'b0, 0);
    run_mix(3'b111, 3'b011, 16'sd100, 16'sd200, 16'sd1234, 2'd0, 1'b0, 0);
    run_mix(3'b010, 3'b111, 16'sd5, 16'sd7, 16'sd9, 2'd0, 1'b0, 0);
    run_mix(3'b010, 3'b111, 16'sd5, 16'sd7, 16'sd9, 2'd0, 1'b1, 0);
    run_mix(3'b000, 3'b111, 16'sd5, 16'sd7, 16'sd9, 2'd0, 1'b0, 0);
    run_mix(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd0, 1'b0, 5);
    run_mix(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd0, 1'b0, 7);

    for (int n = 0; n < 6; n++) begin
      rm = NV'($urandom_range(0, 7));
      r0 = SW'($urandom_range(0, 65535));
      r1 = SW'($urandom_range(0, 65535));
      r2 = SW'($urandom_range(0, 65535));
      rg = 2'($urandom_range(0, 3));
      run_mix(rm, 3'b111, r0, r1, r2, rg, 1'b0, 0);
    end

    // reset during ACCUM aborts the period
    run_mix(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd0, 1'b0, 0);
    vc0 = valid_cnt;
    drive_period(3'b111, 3'b111, 16'sd1000, 16'sd2000, -16'sd500, 2'd0, 1'b0, gen_c);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_sample_out", 32'(bus.sample_out), 32'd0);
    check("abort_valid", 32'(bus.sample_valid), 32'd0);
    check("abort_missed", 32'(bus.missed_voices), 32'd0);
    check("abort_overrun", 32'(bus.overrun), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (10) tick();
    check("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of note-player voices mixed.
REQ-002 Parameter SAMPLE_WIDTH, default 16: width of each voice sample and of the mixed output.
REQ-003 Parameter TIMEOUT, default 64: maximum number of COLLECT cycles spent waiting for voice samples.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 generate_next_sample  input  1  one-cycle pulse that starts a sample period.
REQ-007 voice_samples  input  NUM_VOICES*SAMPLE_WIDTH  two's-complement samples; voice i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-008 voice_ready  input  NUM_VOICES  per-voice pulse; voice i's sample is valid in that cycle.
REQ-009 voice_mask  input  NUM_VOICES  1 = voice included in the mix.
REQ-010 gain_shift  input  2  arithmetic right shift (0-3) applied to the sum.
REQ-011 mute  input  1  forces the mixed output to zero.
REQ-012 sample_out  output  SAMPLE_WIDTH  mixed, saturated sample.
REQ-013 sample_valid  output  1  one-cycle strobe marking a new sample_out.
REQ-014 missed_voices  output  NUM_VOICES  masked voices that timed out in the last period.
REQ-015 overrun  output  1  one-cycle pulse when generate_next_sample arrives while busy.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, COLLECT, ACCUM, OUTPUT.
REQ-018 IDLE + generate_next_sample: go to COLLECT; clear capture flags; clear wait timer; latch voice_mask for the period.
REQ-019 COLLECT capture rule: each cycle, for each voice i that is latched-masked, not yet captured, and has voice_ready[i]=1, register its sample and set its flag.
REQ-020 COLLECT ignores repeat ready pulses from an already-captured voice and ignores ready pulses seen in IDLE.
REQ-021 COLLECT exits to ACCUM when every latched-masked voice is captured, counting captures made in the current cycle.
REQ-022 COLLECT also exits to ACCUM after TIMEOUT cycles; each masked, uncaptured voice contributes 0 and sets its missed_voices bit.
REQ-023 All-zero latched mask: exactly one COLLECT cycle, then ACCUM.
REQ-024 ACCUM takes NUM_VOICES cycles and adds one sign-extended captured sample per cycle, in index order 0..NUM_VOICES-1.
REQ-025 Accumulator width is SAMPLE_WIDTH + clog2(NUM_VOICES); it never overflows internally.
REQ-026 OUTPUT computes result = accumulator arithmetically right-shifted by gain_shift (rounding toward minus infinity).
REQ-027 OUTPUT saturates result to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
REQ-028 mute=1 in the OUTPUT cycle forces sample_out to 0; sample_valid still pulses.
REQ-029 OUTPUT sample timing: sample_out is registered, sample_valid is high for exactly one cycle, then the FSM returns to IDLE.
REQ-030 Latency: if the last required voice_ready is sampled in cycle t, sample_valid is high in cycle t+NUM_VOICES+1.
REQ-031 sample_out holds its value between strobes.
REQ-032 missed_voices updates at the end of COLLECT and holds until the next COLLECT exit.
REQ-033 generate_next_sample in any non-IDLE state is ignored and pulses overrun the next cycle; the in-flight mix is unaffected.
REQ-034 generate_next_sample arriving in the same cycle as the OUTPUT-to-IDLE transition is an overrun.
REQ-035 gain_shift and mute are sampled only in the OUTPUT cycle.

Reset
REQ-036 reset=0 at a clock edge: state goes to IDLE; accumulator, capture flags, timer, sample_out, sample_valid, missed_voices, overrun and busy all go to 0.
REQ-037 Reset asserted mid-period aborts it; no sample_valid is produced for the aborted period.
REQ-038 The block takes no action in the first cycle after reset is released unless generate_next_sample is present.

Verification (NUM_VOICES=3, SAMPLE_WIDTH=16, TIMEOUT=64)
REQ-039 Basic mix: mask=111, samples 1000/2000/-500 with ready pulses in cycles t-2, t-1, t, gain 0 -> sample_out=2500 and sample_valid high only in cycle t+4.
REQ-040 Saturation: samples 30000 x3 -> 32767; samples -30000 x3 -> -32768.
REQ-041 Gain shift: sum 2500 with gain_shift=2 -> 625; sum -7 with gain_shift=1 -> -4.
REQ-042 Timeout: mask=111, voice 2 never ready, voices 0/1 = 100/200 -> valid after 64 COLLECT cycles with sample_out=300 and missed_voices=100b.
REQ-043 Mask and mute: mask=010, all voices ready with 5/7/9 -> 7; repeat with mute=1 -> 0 with valid still pulsed.
REQ-044 Disturbance: generate_next_sample during ACCUM -> overrun pulses, mix result unchanged; reset=0 during ACCUM -> no valid, all outputs 0.
